// File: rtl/pe_alu_join.sv
// pe_alu_join: two-operand functional-unit stage of a CGRA processing element.
// Joins operand streams A and B with a valid/ready handshake. Applies the
// opcode on io_cfg and presents a registered result. Opcode 11 is a
// multiply-accumulate mode that emits one result per ACC_LEN operand pairs.
// Optional feature macro: PE_ALU_JOIN_SAT_EN. When it is defined, ADD, SUB,
// MUL and the MAC arithmetic use signed saturation instead of wrapping.
module pe_alu_join #(
    parameter int WIDTH   = 32,
    parameter int ACC_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       io_cfg,
    input  logic [WIDTH-1:0] io_din_a,
    input  logic             io_din_a_v,
    output logic             io_din_a_r,
    input  logic [WIDTH-1:0] io_din_b,
    input  logic             io_din_b_v,
    output logic             io_din_b_r,
    output logic [WIDTH-1:0] io_dout,
    output logic             io_dout_v,
    input  logic             io_dout_r
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [7:0] CNT_LAST = 8'(ACC_LEN - 1);
    localparam bit MAC_SINGLE = (ACC_LEN == 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_MIN   = 4'd9;
    localparam logic [3:0] OP_MAX   = 4'd10;
    localparam logic [3:0] OP_MAC   = 4'd11;
    localparam logic [3:0] OP_PASSA = 4'd12;

`ifdef PE_ALU_JOIN_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic {S_RUN = 1'b0, S_ACC = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [7:0]       cnt_q;
    logic [3:0]       cfg_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_v_q;

    logic             out_free_s;
    logic             abort_s;
    logic             fire_s;
    logic [WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] macsum_s;
    logic [WIDTH-1:0] result_d;
    logic [SHW-1:0]   sh_s;
    logic signed [WIDTH-1:0] a_sgn_s;

    // Addition: signed saturating when enabled, otherwise modular.
    function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef PE_ALU_JOIN_SAT_EN
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            return s[WIDTH-1:0];
        end
`else
        return a + b;
`endif
    endfunction

    // Subtraction: signed saturating when enabled, otherwise modular.
    function automatic logic [WIDTH-1:0] sub_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef PE_ALU_JOIN_SAT_EN
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            return s[WIDTH-1:0];
        end
`else
        return a - b;
`endif
    endfunction

    // Multiply: the full signed product is clamped to WIDTH bits when
    // saturation is enabled; otherwise the low WIDTH bits are kept.
    function automatic logic [WIDTH-1:0] mul_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef PE_ALU_JOIN_SAT_EN
        logic [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        if ((p[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b0}}) ||
            (p[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b1}})) begin
            return p[WIDTH-1:0];
        end else begin
            return p[2*WIDTH-1] ? MIN_NEG : MAX_POS;
        end
`else
        return a * b;
`endif
    endfunction

    // A change of opcode in the middle of an accumulation group cancels the
    // group. Both readies are held low in that cycle so no pair is lost.
    assign out_free_s = ~dout_v_q | io_dout_r;
    assign abort_s    = (state_q == S_ACC) && (io_cfg != cfg_q);
    assign io_din_a_r = io_din_b_v & out_free_s & ~abort_s;
    assign io_din_b_r = io_din_a_v & out_free_s & ~abort_s;
    assign fire_s     = io_din_a_v & io_din_b_v & out_free_s & ~abort_s;
    assign io_dout    = dout_q;
    assign io_dout_v  = dout_v_q;

    // Combinational ALU: compute the single-cycle result for the current opcode.
    always_comb begin
        sh_s     = io_din_b[SHW-1:0];
        a_sgn_s  = io_din_a;
        prod_s   = mul_op(io_din_a, io_din_b);
        macsum_s = add_op(acc_q, prod_s);
        result_d = {WIDTH{1'b0}};
        case (io_cfg)
            OP_ADD:   result_d = add_op(io_din_a, io_din_b);
            OP_SUB:   result_d = sub_op(io_din_a, io_din_b);
            OP_MUL:   result_d = prod_s;
            OP_AND:   result_d = io_din_a & io_din_b;
            OP_OR:    result_d = io_din_a | io_din_b;
            OP_XOR:   result_d = io_din_a ^ io_din_b;
            OP_SHL:   result_d = io_din_a << sh_s;
            OP_SHR:   result_d = io_din_a >> sh_s;
            OP_SRA:   result_d = a_sgn_s >>> sh_s;
            OP_MIN:   result_d = ($signed(io_din_a) < $signed(io_din_b)) ? io_din_a : io_din_b;
            OP_MAX:   result_d = ($signed(io_din_a) > $signed(io_din_b)) ? io_din_a : io_din_b;
            OP_MAC:   result_d = prod_s;
            OP_PASSA: result_d = io_din_a;
            default:  result_d = {WIDTH{1'b0}};
        endcase
    end

    // Sequential state: MAC FSM, accumulator, opcode history and the registered output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_RUN;
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= 8'd0;
            cfg_q    <= 4'd0;
            dout_q   <= {WIDTH{1'b0}};
            dout_v_q <= 1'b0;
        end else begin
            cfg_q <= io_cfg;
            if (abort_s) begin
                state_q  <= S_RUN;
                acc_q    <= {WIDTH{1'b0}};
                cnt_q    <= 8'd0;
                dout_v_q <= dout_v_q & ~io_dout_r;
            end else if (fire_s) begin
                if (state_q == S_ACC) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_q   <= macsum_s;
                        dout_v_q <= 1'b1;
                        acc_q    <= {WIDTH{1'b0}};
                        cnt_q    <= 8'd0;
                        state_q  <= S_RUN;
                    end else begin
                        acc_q    <= macsum_s;
                        cnt_q    <= cnt_q + 8'd1;
                        dout_v_q <= 1'b0;
                    end
                end else if ((io_cfg == OP_MAC) && !MAC_SINGLE) begin
                    acc_q    <= prod_s;
                    cnt_q    <= 8'd1;
                    state_q  <= S_ACC;
                    dout_v_q <= 1'b0;
                end else begin
                    dout_q   <= result_d;
                    dout_v_q <= 1'b1;
                end
            end else if (io_dout_r) begin
                dout_v_q <= 1'b0;
            end else begin
                dout_v_q <= dout_v_q;
            end
        end
    end

endmodule

// File: tb/tb_pe_alu_join.sv
// Testbench for pe_alu_join: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_pe_alu_join;

    localparam int W       = 32;
    localparam int ACC_LEN = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    io_cfg;
    logic [W-1:0]  io_din_a;
    logic          io_din_a_v;
    logic          io_din_a_r;
    logic [W-1:0]  io_din_b;
    logic          io_din_b_v;
    logic          io_din_b_r;
    logic [W-1:0]  io_dout;
    logic          io_dout_v;
    logic          io_dout_r;

    pe_alu_join #(.WIDTH(W), .ACC_LEN(ACC_LEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_cfg     (io_cfg),
        .io_din_a   (io_din_a),
        .io_din_a_v (io_din_a_v),
        .io_din_a_r (io_din_a_r),
        .io_din_b   (io_din_b),
        .io_din_b_v (io_din_b_v),
        .io_din_b_r (io_din_b_r),
        .io_dout    (io_dout),
        .io_dout_v  (io_dout_v),
        .io_dout_r  (io_dout_r)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the expected output register, the pairs of the
    // MAC group collected so far, and the opcode seen in the previous cycle.
    logic          exp_v;
    logic [W-1:0]  exp_dout;
    logic [3:0]    cfg_prev;
    logic [W-1:0]  grp_a[$];
    logic [W-1:0]  grp_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint to_l(input logic [31:0] x);
        int i;
        i = x;
        return longint'(i);
    endfunction

    // Map an exact signed result onto 32 bits: clamp or wrap.
    function automatic logic [31:0] clamp(input longint v);
`ifdef PE_ALU_JOIN_SAT_EN
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        return clamp(to_l(a) + to_l(b));
    endfunction

    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        return clamp(to_l(a) - to_l(b));
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return clamp(to_l(a) * to_l(b));
    endfunction

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] na;
        sh = b[4:0];
        na = ~a;
        case (op)
            4'd0:    return ref_add(a, b);
            4'd1:    return ref_sub(a, b);
            4'd2:    return ref_mul(a, b);
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return a[31] ? ~(na >> sh) : (a >> sh);
            4'd9:    return (to_l(a) < to_l(b)) ? a : b;
            4'd10:   return (to_l(a) > to_l(b)) ? a : b;
            4'd11:   return ref_mul(a, b);
            4'd12:   return a;
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle: drive inputs, check DUT against the model mid-cycle,
    // then advance the model to what the next edge should produce.
    task automatic step(input logic [3:0] cfg, input logic [31:0] a, input logic av,
                        input logic [31:0] b, input logic bv, input logic dr, input logic rst);
        logic free, abort, fire;
        logic [31:0] acc;
        io_cfg = cfg; io_din_a = a; io_din_a_v = av; io_din_b = b; io_din_b_v = bv;
        io_dout_r = dr; reset = rst;
        @(negedge clock);
        check("dout_v", {31'd0, io_dout_v}, {31'd0, exp_v});
        check("dout", io_dout, exp_dout);
        if (rst) begin
            exp_v = 1'b0; exp_dout = 32'd0; cfg_prev = 4'd0;
            grp_a.delete(); grp_b.delete();
        end else begin
            free  = !exp_v || dr;
            abort = (grp_a.size() != 0) && (cfg != cfg_prev);
            fire  = av && bv && free && !abort;
            check("din_a_r", {31'd0, io_din_a_r}, {31'd0, bv && free && !abort});
            check("din_b_r", {31'd0, io_din_b_r}, {31'd0, av && free && !abort});
            if (abort) begin
                grp_a.delete(); grp_b.delete();
                if (dr) exp_v = 1'b0;
            end else if (fire) begin
                if (cfg == 4'd11) begin
                    grp_a.push_back(a); grp_b.push_back(b);
                    if (grp_a.size() == ACC_LEN) begin
                        acc = 32'd0;
                        foreach (grp_a[i]) acc = ref_add(acc, ref_mul(grp_a[i], grp_b[i]));
                        grp_a.delete(); grp_b.delete();
                        exp_dout = acc; exp_v = 1'b1;
                    end else begin
                        exp_v = 1'b0;
                    end
                end else begin
                    exp_dout = ref_op(cfg, a, b); exp_v = 1'b1;
                end
            end else if (dr) begin
                exp_v = 1'b0;
            end
            cfg_prev = cfg;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] rcfg;
        exp_v = 1'b0; exp_dout = 32'd0; cfg_prev = 4'd0;

        // Reset state.
        step(4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("reset_dout", io_dout, 32'd0);
        check("reset_dout_v", {31'd0, io_dout_v}, 32'd0);

        // ADD 5+7, then a stream of 8 pairs.
        step(4'd0, 32'd5, 1'b1, 32'd7, 1'b1, 1'b1, 1'b0);
        check("add_5_7", io_dout, 32'd12);
        check("add_5_7_v", {31'd0, io_dout_v}, 32'd1);
        for (int i = 0; i < 8; i++) step(4'd0, 32'(i), 1'b1, 32'(3 * i), 1'b1, 1'b1, 1'b0);
        check("stream_last", io_dout, 32'd28);

        // Join skew: A waits three cycles for B.
        for (int i = 0; i < 3; i++) step(4'd0, 32'd100, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0);
        step(4'd0, 32'd100, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0);
        check("skew_result", io_dout, 32'd101);

        // Backpressure with SUB 3-5.
        step(4'd1, 32'd3, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0);
        check("sub_3_5", io_dout, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) step(4'd1, 32'd10, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);
        check("bp_hold", io_dout, 32'hFFFF_FFFE);
        step(4'd1, 32'd10, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0);
        check("bp_release", io_dout, 32'd6);

        // MAC group of four pairs, then an aborted group, then a fresh group.
        step(4'd11, 32'd1, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd3, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd5, 1'b1, 32'd6, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd7, 1'b1, 32'd8, 1'b1, 1'b1, 1'b0);
        check("mac_100", io_dout, 32'd100);
        step(4'd11, 32'd9, 1'b1, 32'd9, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd9, 1'b1, 32'd9, 1'b1, 1'b1, 1'b0);
        step(4'd0, 32'd9, 1'b1, 32'd9, 1'b1, 1'b1, 1'b0);
        check("abort_no_out", {31'd0, io_dout_v}, 32'd0);
        step(4'd11, 32'd1, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd3, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd5, 1'b1, 32'd6, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd7, 1'b1, 32'd8, 1'b1, 1'b1, 1'b0);
        check("mac_after_abort", io_dout, 32'd100);

        // Shift, compare and undefined opcode.
        step(4'd8, 32'h8000_0000, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0);
        check("sra", io_dout, 32'hF800_0000);
        step(4'd9, 32'hFFFF_FFFD, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0);
        check("min", io_dout, 32'hFFFF_FFFD);
        step(4'd14, 32'd55, 1'b1, 32'd66, 1'b1, 1'b1, 1'b0);
        check("op14", io_dout, 32'd0);

        // Overflow boundary of ADD.
        step(4'd0, 32'h7FFF_FFFF, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0);
`ifdef PE_ALU_JOIN_SAT_EN
        check("add_ovf", io_dout, 32'h7FFF_FFFF);
`else
        check("add_ovf", io_dout, 32'h8000_0000);
`endif

        // Reset during a fire and in the middle of a MAC group.
        step(4'd0, 32'd1, 1'b1, 32'd1, 1'b1, 1'b1, 1'b1);
        check("rst_fire_v", {31'd0, io_dout_v}, 32'd0);
        step(4'd11, 32'd50, 1'b1, 32'd50, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd50, 1'b1, 32'd50, 1'b1, 1'b1, 1'b1);
        step(4'd11, 32'd1, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd3, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd5, 1'b1, 32'd6, 1'b1, 1'b1, 1'b0);
        step(4'd11, 32'd7, 1'b1, 32'd8, 1'b1, 1'b1, 1'b0);
        check("mac_after_reset", io_dout, 32'd100);

        // Randomized traffic with occasional opcode changes and resets.
        rcfg = 4'd11;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) rcfg = 4'($urandom_range(0, 15));
            step(rcfg, rand_operand(), 1'($urandom_range(0, 9) < 7),
                 rand_operand(), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
